fc_stream_mac: RTL
==================

// Module: fc_stream_mac
// PURPOSE
//   Fully-connected layer stage directly downstream of max pooling.
//   Consumes the pooled feature map as a serial stream of signed Q16.16 words.
//   Multiplies each word against a weight row held in external synchronous memory, accumulating N_OUT neurons.
//   Then streams the N_OUT results to the next stage over valid/ready.
// PARAMETERS
//   DATA_BITS  32    width of activations, weights and results (signed, Q16.16)
//   N_IN       529   input words per frame (pooled H*W*D flattened, channel-major)
//   N_OUT      10    output neurons / accumulators
//   ADDR_BITS  16    weight address width; must satisfy 2**ADDR_BITS >= N_IN*N_OUT
// PORTS
//   clk          in   1            rising-edge clock
//   reset        in   1            asynchronous, active-high
//   in_data      in   DATA_BITS    pooled activation word
//   in_valid     in   1            in_data valid
//   in_ready     out  1            stage accepts in_data this cycle
//   weight_addr  out  ADDR_BITS    weight memory read address
//   weight_data  in   DATA_BITS    weight word; returned 1 cycle after weight_addr
//   out_data     out  DATA_BITS    neuron result
//   out_valid    out  1            out_data valid
//   out_ready    in   1            downstream accepts out_data
//   busy         out  1            high in any state except IDLE
// BEHAVIOUR
// - Reset (async): state=IDLE, i=0, j=0, all accumulators=0.
//   Outputs in_ready=1, out_valid=0, out_data=0, weight_addr=0, busy=0.
// - Reset asserted mid-frame discards the frame; no partial results are emitted.
// - FSM states: IDLE, MAC, DRAIN, OUT.
// - IDLE: in_ready=1.
//   On in_valid&in_ready: latch x=in_data, set j=0, drive weight_addr=i*N_OUT, go to MAC.
// - MAC: in_ready=0. Each cycle, weight_addr=i*N_OUT+j+1 while j+1<N_OUT.
//   weight_data (for index j) is applied as acc[j] += sat(x*w), then j++.
//   After j reaches N_OUT-1 the state goes to DRAIN.
// - DRAIN: one cycle; the last product is applied.
//   If i==N_IN-1: set i=0 and go to OUT. Otherwise set i=i+1 and go to IDLE.
// - Timing: each input costs 1 (accept) + N_OUT (MAC/DRAIN) cycles.
//   Input throughput is one word per N_OUT+1 cycles.
// - OUT: out_valid=1 and out_data=f(acc[k]) for k=0..N_OUT-1.
//   k advances only on out_valid&out_ready.
//   out_data/out_valid hold stable while out_ready=0.
//   After the handshake with k=N_OUT-1: clear all acc, set k=0, out_valid=0 next cycle, return to IDLE.
//   First output is valid the cycle after DRAIN of the last input.
// - in_ready=0 throughout OUT. No overlap between frames; upstream must stall.
// - Arithmetic:
//   - Product is the full 2*DATA_BITS signed value.
//   - Scaled = product[DATA_BITS+15:16], i.e. Q16.16 truncation toward -inf.
//   - The scaled value saturates to [-2^31, 2^31-1] if the product exceeds that range.
//   - The accumulate add also saturates to the same range; the accumulator never wraps.
// - in_valid while in_ready=0 is ignored (data not consumed).
//   out_ready without out_valid has no effect.
// CONFIGURATION
//   RELU_OUT_EN defined:
//     f(a) = (a<0) ? 0 : a. ReLU is applied only at output; accumulators store raw sums.
//   RELU_OUT_EN undefined:
//     f(a) = a. Signed sums are passed through unchanged.
// TESTING
//   1) Reset, N_IN=2, N_OUT=2, identity-like weights {w00=1.0,w01=0,w10=0,w11=1.0}, inputs 3.0, -2.0:
//      -> outputs 0x00030000, 0xFFFE0000. With RELU_OUT_EN the second output is 0.
//   2) Timing, N_OUT=10: in_valid held high -> in_ready high 1 cycle in every 11.
//      weight_addr sequence 0..9, 10..19 per input; first out_valid the cycle after DRAIN of last input.
//   3) Backpressure: hold out_ready=0 for 5 cycles on k=1 -> out_data stable, no skip or duplicate.
//      Exactly N_OUT handshakes complete, then in_ready=1.
//   4) Saturation: x=0x7FFFFFFF, w=0x7FFFFFFF, repeated over 3 inputs -> result 0x7FFFFFFF.
//      Negative case -> 0x80000000. No wrap.
//   5) Reset asserted during MAC of input 5 -> all outputs at reset values immediately.
//      A new frame then gives results equal to a fresh run (accumulators cleared).
//   6) Two back-to-back frames with different data -> frame 2 results contain no frame 1 residue.

Source files
------------

// File: rtl/fc_stream_mac.sv
// Fully-connected MAC stage: serial Q16.16 activations times external weight rows, N_OUT saturating accumulators.
// Optional macro RELU_OUT_EN applies ReLU to results at the output port only.
module fc_stream_mac #(
  parameter int DATA_BITS = 32,
  parameter int N_IN      = 529,
  parameter int N_OUT     = 10,
  parameter int ADDR_BITS = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DATA_BITS-1:0] in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [ADDR_BITS-1:0] weight_addr,
  input  logic [DATA_BITS-1:0] weight_data,
  output logic [DATA_BITS-1:0] out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 busy
);

  localparam int I_W = (N_IN  > 1) ? $clog2(N_IN)  : 1;
  localparam int J_W = (N_OUT > 1) ? $clog2(N_OUT) : 1;
  localparam logic [I_W-1:0] I_LAST = I_W'(N_IN - 1);
  localparam logic [J_W-1:0] J_LAST = J_W'(N_OUT - 1);
  localparam logic [J_W-1:0] J_PRE  = J_W'(N_OUT - 2);
  localparam logic signed [DATA_BITS-1:0] MAX_V = {1'b0, {(DATA_BITS-1){1'b1}}};
  localparam logic signed [DATA_BITS-1:0] MIN_V = {1'b1, {(DATA_BITS-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, MAC, DRAIN, OUT} state_t;

  state_t                       state, state_nxt;
  logic [I_W-1:0]               i;
  logic [J_W-1:0]               j, k;
  logic [ADDR_BITS-1:0]         base;
  logic signed [DATA_BITS-1:0]  x;
  logic signed [DATA_BITS-1:0]  acc [N_OUT];

  logic signed [2*DATA_BITS-1:0] prod;
  logic [DATA_BITS-16:0]         prod_hi;
  logic signed [DATA_BITS-1:0]   scaled;
  logic signed [DATA_BITS-1:0]   acc_sel;
  logic signed [DATA_BITS:0]     sum;
  logic signed [DATA_BITS-1:0]   acc_new;

  // Scaled product fits only if every bit above the kept window matches its sign bit.
  always_comb begin
    prod    = x * $signed(weight_data);
    prod_hi = prod[2*DATA_BITS-1:DATA_BITS+15];
    if ((&prod_hi) || !(|prod_hi)) scaled = prod[DATA_BITS+15:16];
    else if (prod[2*DATA_BITS-1])  scaled = MIN_V;
    else                           scaled = MAX_V;
    acc_sel = acc[j];
    sum     = {acc_sel[DATA_BITS-1], acc_sel} + {scaled[DATA_BITS-1], scaled};
    if (sum[DATA_BITS] == sum[DATA_BITS-1]) acc_new = sum[DATA_BITS-1:0];
    else if (sum[DATA_BITS])                acc_new = MIN_V;
    else                                    acc_new = MAX_V;
  end

  always_comb begin
    state_nxt   = state;
    in_ready    = 1'b0;
    busy        = 1'b1;
    out_valid   = 1'b0;
    weight_addr = '0;
    case (state)
      IDLE: begin
        in_ready    = 1'b1;
        busy        = 1'b0;
        weight_addr = base;
        if (in_valid) state_nxt = MAC;
      end
      MAC: begin
        weight_addr = base + ADDR_BITS'(j) + ADDR_BITS'(1);
        if (j == J_PRE) state_nxt = DRAIN;
      end
      DRAIN: state_nxt = (i == I_LAST) ? OUT : IDLE;
      OUT: begin
        out_valid = 1'b1;
        if (out_ready && k == J_LAST) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    out_data = '0;
    if (out_valid) begin
`ifdef RELU_OUT_EN
      out_data = acc[k][DATA_BITS-1] ? '0 : acc[k];
`else
      out_data = acc[k];
`endif
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      i     <= '0;
      j     <= '0;
      k     <= '0;
      base  <= '0;
      x     <= '0;
      for (int unsigned n = 0; n < N_OUT; n++) acc[n] <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (in_valid) begin
          x <= in_data;
          j <= '0;
        end
        MAC: begin
          acc[j] <= acc_new;
          j      <= j + J_W'(1);
        end
        DRAIN: begin
          acc[j] <= acc_new;
          if (i == I_LAST) begin
            i    <= '0;
            base <= '0;
          end else begin
            i    <= i + I_W'(1);
            base <= base + ADDR_BITS'(N_OUT);
          end
        end
        OUT: if (out_ready) begin
          if (k == J_LAST) begin
            k <= '0;
            for (int unsigned n = 0; n < N_OUT; n++) acc[n] <= '0;
          end else begin
            k <= k + J_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
